// File: rtl/sort_batch_ctrl.sv
// sort_batch_ctrl: shares one fixed-latency sorting network with a narrow record stream.
// Records are packed one per cycle into batches of 2^P_LOG. A flushed partial batch is padded
// with all-ones records. A batch is launched only while a result slot is reserved (credit).
// Sorted results are unpacked back into a stream, and the padding is dropped.
// Ports:
//   CLK, RST_X           clock, async active-low reset
//   S_DIN/S_DINEN/S_RDY  input record stream; S_FLUSH closes a partial batch
//   N_DIN/N_DINEN        batch launch to the network (lane i = DATW*(i+1)-1:DATW*i)
//   N_DOT/N_DOTEN        sorted batch from the network, lane 0 = smallest key
//   M_DOT/M_DOTEN/M_RDY  output record stream; M_LAST marks the last real record of a batch
//   BUSY                 any record held or in flight
module sort_batch_ctrl #(
    parameter int unsigned P_LOG = 3,
    parameter int unsigned DATW  = 64,
    parameter int unsigned KEYW  = 32
) (
    input  logic                      CLK,
    input  logic                      RST_X,
    input  logic [DATW-1:0]           S_DIN,
    input  logic                      S_DINEN,
    input  logic                      S_FLUSH,
    output logic                      S_RDY,
    output logic [(DATW<<P_LOG)-1:0]  N_DIN,
    output logic                      N_DINEN,
    input  logic [(DATW<<P_LOG)-1:0]  N_DOT,
    input  logic                      N_DOTEN,
    output logic [DATW-1:0]           M_DOT,
    output logic                      M_DOTEN,
    input  logic                      M_RDY,
    output logic                      M_LAST,
    output logic                      BUSY
);

    localparam int unsigned NL = 1 << P_LOG;
    localparam int unsigned BW = DATW << P_LOG;
    localparam int unsigned CW = P_LOG + 1;

    typedef enum logic {ST_FILL, ST_ISSUE} state_t;

    state_t             r_state, w_state_nxt;
    logic [DATW-1:0]    r_lane [NL];
    logic [DATW-1:0]    w_lane_nxt [NL];
    logic [CW-1:0]      r_wcnt, w_wcnt_nxt, w_wcnt_inc;
    logic [1:0]         r_credit, w_credit_nxt;
    logic [BW-1:0]      r_rf_mem [2];
    logic [BW-1:0]      w_rf_mem_nxt [2];
    logic               r_rf_wp, r_rf_rp, w_rf_rp_nxt;
    logic [1:0]         r_rf_cnt, w_rf_cnt_nxt;
    logic [CW-1:0]      r_cf_mem [2];
    logic [CW-1:0]      w_cf_mem_nxt [2];
    logic               r_cf_wp, r_cf_rp, w_cf_rp_nxt;
    logic [P_LOG-1:0]   r_rcnt, w_rcnt_nxt;
    logic               w_accept, w_launch, w_xfer, w_pop, w_rpush;
    logic [BW-1:0]      w_ndin_nxt, w_head;
    logic [CW-1:0]      w_cnt_head;
    logic               w_ndinen_nxt, w_mdoten_nxt, w_sorted_ok;

    logic               r_s_rdy, r_n_dinen, r_m_doten, r_m_last, r_busy;
    logic [BW-1:0]      r_n_din;
    logic [DATW-1:0]    r_m_dot;

    assign S_RDY   = r_s_rdy;
    assign N_DIN   = r_n_din;
    assign N_DINEN = r_n_dinen;
    assign M_DOT   = r_m_dot;
    assign M_DOTEN = r_m_doten;
    assign M_LAST  = r_m_last;
    assign BUSY    = r_busy;

    // Next-state logic: packer FSM, credits, result/count FIFOs, unpacker, registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        w_wcnt_nxt  = r_wcnt;
        w_launch    = 1'b0;
        w_accept    = S_DINEN & r_s_rdy;
        w_wcnt_inc  = r_wcnt + CW'(w_accept);

        case (r_state)
            ST_FILL: begin
                if (w_accept) w_lane_nxt[r_wcnt[P_LOG-1:0]] = S_DIN;
                w_wcnt_nxt = w_wcnt_inc;
                // A flush counts the record arriving in the same cycle; a full batch wins once.
                if ((w_wcnt_inc == CW'(NL)) || (S_FLUSH && (w_wcnt_inc != '0)))
                    w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (r_credit != 2'd0) begin
                    w_launch    = 1'b1;
                    w_wcnt_nxt  = '0;
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase

        w_xfer  = r_m_doten & M_RDY;
        w_pop   = w_xfer & r_m_last;
        w_rpush = N_DOTEN & (r_rf_cnt != 2'd2);

        // Launch uses the pre-update credit; a same-cycle return keeps the net count.
        w_credit_nxt = r_credit - 2'(w_launch) + 2'(w_pop);

        w_rf_mem_nxt = r_rf_mem;
        if (w_rpush) w_rf_mem_nxt[r_rf_wp] = N_DOT;
        w_rf_rp_nxt  = r_rf_rp ^ w_pop;
        w_rf_cnt_nxt = r_rf_cnt + 2'(w_rpush) - 2'(w_pop);

        w_cf_mem_nxt = r_cf_mem;
        if (w_launch) w_cf_mem_nxt[r_cf_wp] = r_wcnt;
        w_cf_rp_nxt  = r_cf_rp ^ w_pop;

        w_rcnt_nxt = w_pop ? '0 : (w_xfer ? r_rcnt + P_LOG'(1) : r_rcnt);

        w_head       = w_rf_mem_nxt[w_rf_rp_nxt];
        w_cnt_head   = w_cf_mem_nxt[w_cf_rp_nxt];
        w_mdoten_nxt = (w_rf_cnt_nxt != 2'd0);

        // Lanes at or beyond the fill count carry the reserved all-ones pad record.
        for (int unsigned i = 0; i < NL; i++)
            w_ndin_nxt[i*DATW +: DATW] = (CW'(i) < w_wcnt_nxt) ? w_lane_nxt[i] : '1;
        w_ndinen_nxt = (w_state_nxt == ST_ISSUE) && (w_credit_nxt != 2'd0);

        w_sorted_ok = 1'b1;
        for (int unsigned i = 0; i + 1 < NL; i++)
            if (N_DOT[i*DATW +: KEYW] > N_DOT[(i+1)*DATW +: KEYW]) w_sorted_ok = 1'b0;
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state   <= ST_FILL;
            r_wcnt    <= '0;
            r_credit  <= 2'd2;
            for (int unsigned i = 0; i < NL; i++) r_lane[i] <= '0;
            for (int unsigned k = 0; k < 2; k++) begin
                r_rf_mem[k] <= '0;
                r_cf_mem[k] <= '0;
            end
            r_rf_wp   <= 1'b0;
            r_rf_rp   <= 1'b0;
            r_rf_cnt  <= 2'd0;
            r_cf_wp   <= 1'b0;
            r_cf_rp   <= 1'b0;
            r_rcnt    <= '0;
            r_s_rdy   <= 1'b0;
            r_n_dinen <= 1'b0;
            r_n_din   <= '0;
            r_m_doten <= 1'b0;
            r_m_dot   <= '0;
            r_m_last  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_credit  <= w_credit_nxt;
            r_lane    <= w_lane_nxt;
            r_rf_mem  <= w_rf_mem_nxt;
            r_rf_wp   <= r_rf_wp ^ w_rpush;
            r_rf_rp   <= w_rf_rp_nxt;
            r_rf_cnt  <= w_rf_cnt_nxt;
            r_cf_mem  <= w_cf_mem_nxt;
            r_cf_wp   <= r_cf_wp ^ w_launch;
            r_cf_rp   <= w_cf_rp_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_s_rdy   <= (w_state_nxt == ST_FILL);
            r_n_dinen <= w_ndinen_nxt;
            if (w_ndinen_nxt) r_n_din <= w_ndin_nxt;
            r_m_doten <= w_mdoten_nxt;
            r_m_dot   <= w_mdoten_nxt ? w_head[32'(w_rcnt_nxt)*DATW +: DATW] : '0;
            r_m_last  <= w_mdoten_nxt && (CW'(w_rcnt_nxt) == w_cnt_head - CW'(1));
            r_busy    <= (w_wcnt_nxt != '0) || (w_state_nxt == ST_ISSUE) || (w_credit_nxt != 2'd2);
        end
    end

    // Credits guarantee a free result slot; a result into a full FIFO breaks the protocol.
    a_no_result_overflow: assert property (@(posedge CLK) disable iff (!RST_X)
        !(N_DOTEN && (r_rf_cnt == 2'd2)));
    a_result_sorted: assert property (@(posedge CLK) disable iff (!RST_X)
        N_DOTEN |-> w_sorted_ok);

endmodule
